// File: rtl/audio_cfg_seq_pkg.sv
// Shared types and default parameter values for the audio codec configuration
// sequencer and its register table.
package audio_cfg_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    WAIT_HI,
    WAIT_LO,
    DONE,
    ERROR
  } state_t;

  typedef enum logic [1:0] {
    BYTE_ADDR,
    BYTE_REG,
    BYTE_DATA
  } byte_sel_t;

  localparam logic [6:0] DEF_DEV_ADDR  = 7'h1A;
  localparam int         DEF_N_ENTRIES = 11;
  localparam int         DEF_CE_HIGH   = 4;
  localparam int         DEF_TIMEOUT   = 50000;

endpackage

// File: rtl/audio_cfg_rom.sv
// Codec register table: {reg, data} words indexed by entry number.
// Entries beyond the programmed set read as zero.
module audio_cfg_rom (
  input  logic [3:0]  i_index,
  output logic [15:0] o_word
);

  always_comb begin
    o_word = 16'h0000;
    case (i_index)
      4'd0:    o_word = 16'h1E00;
      4'd1:    o_word = 16'h0017;
      4'd2:    o_word = 16'h0217;
      4'd3:    o_word = 16'h0479;
      4'd4:    o_word = 16'h0679;
      4'd5:    o_word = 16'h0812;
      4'd6:    o_word = 16'h0A00;
      4'd7:    o_word = 16'h0C00;
      4'd8:    o_word = 16'h0E42;
      4'd9:    o_word = 16'h1000;
      4'd10:   o_word = 16'h1201;
      default: o_word = 16'h0000;
    endcase
  end

endmodule

// File: rtl/audio_cfg_seq.sv
// Streams the codec register table to a byte-oriented I2C master: three bytes
// per entry, each latched by a copy-enable strobe, then waits for the transfer.
module audio_cfg_seq
  import audio_cfg_seq_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = DEF_DEV_ADDR,
  parameter int         N_ENTRIES = DEF_N_ENTRIES,
  parameter int         CE_HIGH   = DEF_CE_HIGH,
  parameter int         TIMEOUT   = DEF_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       i2c_busy,
  output logic [7:0] i2c_din,
  output logic       i2c_copy_enable,
  output logic [3:0] index,
  output logic       done,
  output logic       error
);

  state_t      r_state, w_stateNext;
  byte_sel_t   r_byteSel, w_byteSelNext;
  logic [3:0]  r_index, w_indexNext;
  logic [15:0] r_pulseCnt, w_pulseCntNext;
  logic [15:0] r_toCnt, w_toCntNext;
  logic        r_done, w_doneNext;
  logic        r_error, w_errorNext;
  logic [7:0]  r_din, w_dinNext;
  logic        r_ce, w_ceNext;
  logic [16:0] w_toInc;
  logic        w_toExpired;
  logic [15:0] w_romWord;

  // Table is addressed by the next index so the output byte register loads
  // the correct value on the same edge the entry advances.
  audio_cfg_rom u_rom (
    .i_index (w_indexNext),
    .o_word  (w_romWord)
  );

  always_comb begin
    w_stateNext    = r_state;
    w_byteSelNext  = r_byteSel;
    w_indexNext    = r_index;
    w_pulseCntNext = r_pulseCnt;
    w_toCntNext    = r_toCnt;
    w_doneNext     = r_done;
    w_errorNext    = r_error;
    w_toInc        = {1'b0, r_toCnt} + 17'd1;
    w_toExpired    = (w_toInc == 17'(TIMEOUT));

    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_stateNext   = SETUP;
          w_indexNext   = 4'd0;
          w_byteSelNext = BYTE_ADDR;
          w_doneNext    = 1'b0;
          w_errorNext   = 1'b0;
        end
      end
      SETUP: begin
        w_stateNext    = PULSE;
        w_pulseCntNext = 16'd0;
      end
      PULSE: begin
        if (r_pulseCnt == 16'(CE_HIGH - 1)) w_stateNext = HOLD;
        else w_pulseCntNext = r_pulseCnt + 16'd1;
      end
      HOLD: begin
        case (r_byteSel)
          BYTE_ADDR: begin
            w_byteSelNext = BYTE_REG;
            w_stateNext   = SETUP;
          end
          BYTE_REG: begin
            w_byteSelNext = BYTE_DATA;
            w_stateNext   = SETUP;
          end
          default: begin
            w_stateNext = WAIT_HI;
            w_toCntNext = 16'd0;
          end
        endcase
      end
      WAIT_HI: begin
        w_toCntNext = w_toInc[15:0];
        if (w_toExpired) begin
          w_stateNext = ERROR;
          w_errorNext = 1'b1;
        end else if (i2c_busy) begin
          w_stateNext = WAIT_LO;
        end
      end
      WAIT_LO: begin
        w_toCntNext = w_toInc[15:0];
        if (w_toExpired) begin
          w_stateNext = ERROR;
          w_errorNext = 1'b1;
        end else if (!i2c_busy) begin
          if (r_index == 4'(N_ENTRIES - 1)) begin
            w_stateNext = DONE;
            w_doneNext  = 1'b1;
          end else begin
            w_indexNext   = r_index + 4'd1;
            w_byteSelNext = BYTE_ADDR;
            w_stateNext   = SETUP;
          end
        end
      end
      ERROR: w_errorNext = 1'b1;
      default: w_stateNext = IDLE;
    endcase
  end

  // Output values derive from the next state so every port comes straight
  // from a flop; the strobe therefore cannot glitch.
  always_comb begin
    w_dinNext = 8'h00;
    w_ceNext  = (w_stateNext == PULSE);
    if (w_stateNext == SETUP || w_stateNext == PULSE || w_stateNext == HOLD) begin
      case (w_byteSelNext)
        BYTE_ADDR: w_dinNext = {DEV_ADDR, 1'b0};
        BYTE_REG:  w_dinNext = w_romWord[15:8];
        default:   w_dinNext = w_romWord[7:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_byteSel  <= BYTE_ADDR;
      r_index    <= 4'd0;
      r_pulseCnt <= 16'd0;
      r_toCnt    <= 16'd0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_din      <= 8'h00;
      r_ce       <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_byteSel  <= w_byteSelNext;
      r_index    <= w_indexNext;
      r_pulseCnt <= w_pulseCntNext;
      r_toCnt    <= w_toCntNext;
      r_done     <= w_doneNext;
      r_error    <= w_errorNext;
      r_din      <= w_dinNext;
      r_ce       <= w_ceNext;
    end
  end

  assign i2c_din         = r_din;
  assign i2c_copy_enable = r_ce;
  assign index           = r_index;
  assign done            = r_done;
  assign error           = r_error;

endmodule

// File: tb/tb_audio_cfg_seq.sv
// Bench for audio_cfg_seq: three instances (default, short timeout, single
// one-cycle-strobe entry) driven by vector tables, a byte-queue model and a busy model.
`timescale 1ns/1ps
module tb_audio_cfg_seq;

   typedef struct {
      logic       start;
      logic       busy;
      logic [7:0] expDin;
      logic       dinCare;
      logic       expCe;
      logic [3:0] expIndex;
      logic       expDone;
      logic       expError;
   } vector_t;

   localparam logic [7:0] ADDR_BYTE = 8'h34;

   logic       clk = 1'b0;
   logic       reset;

   logic       mainStart, mainBusy;
   logic [7:0] mainDin;
   logic       mainCe, mainDone, mainError;
   logic [3:0] mainIndex;

   logic       toStart, toBusy;
   logic [7:0] toDin;
   logic       toCe, toDone, toError;
   logic [3:0] toIndex;

   logic       oneStart, oneBusy;
   logic [7:0] oneDin;
   logic       oneCe, oneDone, oneError;
   logic [3:0] oneIndex;

   int         vectorCount = 0;
   int         missCount = 0;

   logic [7:0] expQ[$];
   int         strobeCount = 0;
   bit         monRandom = 1'b0;

   vector_t    vecs[15];

   always #5 clk = ~clk;

   audio_cfg_seq dutMain (
      .clk(clk), .reset(reset), .start(mainStart), .i2c_busy(mainBusy),
      .i2c_din(mainDin), .i2c_copy_enable(mainCe), .index(mainIndex),
      .done(mainDone), .error(mainError)
   );

   audio_cfg_seq #(.TIMEOUT(100)) dutTo (
      .clk(clk), .reset(reset), .start(toStart), .i2c_busy(toBusy),
      .i2c_din(toDin), .i2c_copy_enable(toCe), .index(toIndex),
      .done(toDone), .error(toError)
   );

   audio_cfg_seq #(.N_ENTRIES(1), .CE_HIGH(1)) dutOne (
      .clk(clk), .reset(reset), .start(oneStart), .i2c_busy(oneBusy),
      .i2c_din(oneDin), .i2c_copy_enable(oneCe), .index(oneIndex),
      .done(oneDone), .error(oneError)
   );

   // Expected codec table contents, entry by entry.
   function automatic logic [15:0] refWord(input int i);
      case (i)
         0:  return 16'h1E00;
         1:  return 16'h0017;
         2:  return 16'h0217;
         3:  return 16'h0479;
         4:  return 16'h0679;
         5:  return 16'h0812;
         6:  return 16'h0A00;
         7:  return 16'h0C00;
         8:  return 16'h0E42;
         9:  return 16'h1000;
         10: return 16'h1201;
         default: return 16'h0000;
      endcase
   endfunction

   // Queue up the byte stream a complete run must produce.
   task automatic loadRun(input int nEntries);
      logic [15:0] w;
      for (int e = 0; e < nEntries; e++) begin
         w = refWord(e);
         expQ.push_back(ADDR_BYTE);
         expQ.push_back(w[15:8]);
         expQ.push_back(w[7:0]);
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectorCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic reportFail(input string name, input int actual, input int limit);
      vectorCount++;
      missCount++;
      $display("[TB] FAIL %s: got %0d, limit %0d", name, actual, limit);
   endtask

   task automatic applyStimulus(input vector_t v);
      oneStart = v.start;
      oneBusy  = v.busy;
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic waitMainDone(input int budget);
      int n;
      n = 0;
      while (!mainDone && !mainError && n < budget) begin
         tick;
         n++;
      end
      if (n >= budget) reportFail("main done wait", n, budget);
   endtask

   task automatic checkMainIdleOutputs(input string tag);
      checkOutput({tag, " din"}, mainDin, 8'h00);
      checkOutput({tag, " ce"}, mainCe, 1'b0);
      checkOutput({tag, " index"}, mainIndex, 4'd0);
      checkOutput({tag, " done"}, mainDone, 1'b0);
      checkOutput({tag, " error"}, mainError, 1'b0);
   endtask

   // Strobe monitor and I2C master model for the default instance.
   initial begin : monitor
      logic       prevCe;
      logic [7:0] riseDin, expByte;
      int         pulseLen, fallsInEntry, delayCnt, holdCnt;
      prevCe = 1'b0; riseDin = 8'h00; pulseLen = 0; fallsInEntry = 0;
      delayCnt = 0; holdCnt = 0; mainBusy = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            prevCe = 1'b0; pulseLen = 0; fallsInEntry = 0;
            delayCnt = 0; holdCnt = 0; mainBusy = 1'b0;
         end else begin
            if (holdCnt > 0) begin
               holdCnt--;
               if (holdCnt == 0) mainBusy = 1'b0;
            end else if (delayCnt > 0) begin
               delayCnt--;
               if (delayCnt == 0) begin
                  mainBusy = 1'b1;
                  holdCnt = monRandom ? int'($urandom_range(1, 60)) : 200;
               end
            end
            if (mainCe && !prevCe) begin
               riseDin = mainDin;
               pulseLen = 1;
            end else if (mainCe) begin
               pulseLen++;
            end else if (prevCe) begin
               strobeCount++;
               checkOutput("pulse width", pulseLen, 4);
               if (expQ.size() == 0) begin
                  reportFail("unexpected strobe", strobeCount, 0);
               end else begin
                  expByte = expQ.pop_front();
                  checkOutput("strobe byte at fall", mainDin, expByte);
                  checkOutput("strobe byte at rise", riseDin, expByte);
               end
               fallsInEntry++;
               if (fallsInEntry == 3) begin
                  fallsInEntry = 0;
                  delayCnt = monRandom ? int'($urandom_range(1, 20)) : 10;
               end
            end
            prevCe = mainCe;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog: got 500000 ns elapsed, limit 500000 ns");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin : stimulus
      int n, k, base, falls, highs;
      logic prev;

      // Single-entry, one-cycle-strobe run: inputs then expected registered outputs.
      vecs[0]  = '{1'b1, 1'b0, 8'h34, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 8'h34, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 8'h34, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 8'h1E, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 8'h1E, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 8'h1E, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0};
      vecs[14] = '{1'b1, 1'b0, 8'h34, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};

      reset = 1'b1;
      mainStart = 1'b0; toStart = 1'b0; toBusy = 1'b0;
      oneStart = 1'b0; oneBusy = 1'b0;
      repeat (3) tick;
      checkMainIdleOutputs("reset");
      checkOutput("reset to error", toError, 1'b0);
      checkOutput("reset one done", oneDone, 1'b0);
      reset = 1'b0;
      tick;

      $display("[TB] single-entry vector table");
      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i]);
         tick;
         if (vecs[i].dinCare) checkOutput("one din", oneDin, vecs[i].expDin);
         checkOutput("one ce", oneCe, vecs[i].expCe);
         checkOutput("one index", oneIndex, vecs[i].expIndex);
         checkOutput("one done", oneDone, vecs[i].expDone);
         checkOutput("one error", oneError, vecs[i].expError);
      end
      oneStart = 1'b0;

      $display("[TB] full run with fixed busy timing");
      monRandom = 1'b0;
      strobeCount = 0;
      loadRun(11);
      mainStart = 1'b1;
      tick;
      mainStart = 1'b0;
      waitMainDone(20000);
      checkOutput("run1 done", mainDone, 1'b1);
      checkOutput("run1 error", mainError, 1'b0);
      checkOutput("run1 index", mainIndex, 4'd10);
      checkOutput("run1 strobes", strobeCount, 33);
      checkOutput("run1 bytes left", expQ.size(), 0);
      checkOutput("run1 din in done", mainDin, 8'h00);

      $display("[TB] start held high, random busy timing");
      monRandom = 1'b1;
      strobeCount = 0;
      loadRun(11);
      mainStart = 1'b1;
      tick;
      checkOutput("restart from done", mainDone, 1'b0);
      checkOutput("restart index", mainIndex, 4'd0);
      checkOutput("restart din", mainDin, ADDR_BYTE);
      waitMainDone(5000);
      checkOutput("held run done", mainDone, 1'b1);
      checkOutput("held run strobes", strobeCount, 33);
      checkOutput("held run bytes left", expQ.size(), 0);
      loadRun(11);
      tick;
      mainStart = 1'b0;
      checkOutput("held restart done", mainDone, 1'b0);
      checkOutput("held restart index", mainIndex, 4'd0);
      n = 0;
      while (!(mainBusy && mainIndex == 4'd3) && n < 3000) begin
         tick;
         n++;
      end
      if (n >= 3000) reportFail("busy at entry 3 wait", n, 3000);
      tick;
      mainStart = 1'b1;
      tick;
      mainStart = 1'b0;
      checkOutput("extra start ignored", (mainIndex == 4'd3 || mainIndex == 4'd4), 1'b1);
      checkOutput("extra start done", mainDone, 1'b0);
      waitMainDone(5000);
      checkOutput("run3 done", mainDone, 1'b1);
      checkOutput("run3 index", mainIndex, 4'd10);
      checkOutput("run3 strobes", strobeCount, 66);
      checkOutput("run3 bytes left", expQ.size(), 0);

      $display("[TB] reset during second strobe");
      expQ.delete();
      loadRun(11);
      base = strobeCount;
      mainStart = 1'b1;
      tick;
      mainStart = 1'b0;
      n = 0;
      while (!(mainCe && strobeCount == base + 1) && n < 100) begin
         tick;
         n++;
      end
      if (n >= 100) reportFail("byte1 strobe wait", n, 100);
      tick;
      checkOutput("byte1 pulse cycle 2 ce", mainCe, 1'b1);
      reset = 1'b1;
      expQ.delete();
      tick;
      checkMainIdleOutputs("mid-pulse reset");
      tick;
      checkOutput("held reset ce", mainCe, 1'b0);
      reset = 1'b0;
      loadRun(11);
      mainStart = 1'b1;
      tick;
      mainStart = 1'b0;
      checkOutput("post-reset din", mainDin, ADDR_BYTE);
      checkOutput("post-reset index", mainIndex, 4'd0);
      checkOutput("post-reset ce", mainCe, 1'b0);
      tick;
      checkOutput("post-reset pulse ce", mainCe, 1'b1);
      waitMainDone(5000);
      checkOutput("post-reset run done", mainDone, 1'b1);
      checkOutput("post-reset bytes left", expQ.size(), 0);
      checkOutput("main done and error", mainDone & mainError, 1'b0);

      $display("[TB] timeout with silent master");
      toStart = 1'b1;
      tick;
      toStart = 1'b0;
      falls = 0;
      prev = toCe;
      n = 0;
      while (falls < 3 && n < 200) begin
         tick;
         n++;
         if (prev && !toCe) falls++;
         prev = toCe;
      end
      if (n >= 200) reportFail("timeout strobe wait", n, 200);
      k = 0;
      highs = 0;
      while (!toError && k < 300) begin
         tick;
         k++;
         if (toCe) highs++;
      end
      checkOutput("timeout latency", k, 101);
      checkOutput("timeout done", toDone, 1'b0);
      repeat (50) begin
         tick;
         if (toCe) highs++;
      end
      checkOutput("strobes after wait", highs, 0);
      checkOutput("error sticky", toError, 1'b1);
      checkOutput("error din", toDin, 8'h00);
      checkOutput("error done", toDone, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule

// File: doc/audio_cfg_seq.md
AUDIO_CFG_SEQ -- requirements
Module: audio_cfg_seq

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h1A, the 7-bit I2C address of the audio codec.
REQ-002 SHALL have parameter N_ENTRIES, default 11, the number of register/data pairs sent per run (1..16).
REQ-003 SHALL have parameter CE_HIGH, default 4, the copy-enable pulse width in clk cycles (>=1).
REQ-004 SHALL have parameter TIMEOUT, default 50000, the maximum clk cycles spent waiting on the I2C master per entry.
REQ-005 SHALL use one clock, clk; reset is synchronous and active-high, named reset.
REQ-006 SHALL have port clk  input  1  system clock.
REQ-007 SHALL have port reset  input  1  synchronous active-high reset.
REQ-008 SHALL have port start  input  1  level-sampled request to begin a configuration run.
REQ-009 SHALL have port i2c_busy  input  1  busy flag from the downstream I2C master.
REQ-010 SHALL have port i2c_din  output  8  byte presented to the I2C master DIN.
REQ-011 SHALL have port i2c_copy_enable  output  1  byte strobe; the master latches i2c_din on its falling edge.
REQ-012 SHALL have port index  output  4  current table entry.
REQ-013 SHALL have port done  output  1  run completed without error.
REQ-014 SHALL have port error  output  1  master timed out during the run.

Function
REQ-015 SHALL implement states IDLE, SETUP, PULSE, HOLD, WAIT_HI, WAIT_LO, DONE and ERROR.
REQ-016 IDLE or DONE with start=1 SHALL clear index, done and error, select byte 0 and enter SETUP next cycle; start SHALL be ignored in all other states.
REQ-017 Each entry SHALL send three bytes in order: {DEV_ADDR,1'b0}, reg[7:0], data[7:0], where {reg,data} is the 16-bit table word at index.
REQ-018 SETUP SHALL last 1 cycle with i2c_din driving the selected byte and i2c_copy_enable=0.
REQ-019 PULSE SHALL hold i2c_copy_enable=1 for exactly CE_HIGH cycles with i2c_din unchanged.
REQ-020 HOLD SHALL last 1 cycle with i2c_copy_enable=0 and i2c_din unchanged, then go to SETUP for the next byte or, after byte 2, to WAIT_HI.
REQ-021 WAIT_HI SHALL wait for i2c_busy=1, then go to WAIT_LO; WAIT_LO SHALL wait for i2c_busy=0.
REQ-022 On leaving WAIT_LO, if index=N_ENTRIES-1 the block SHALL enter DONE with done=1; otherwise index SHALL increment and the block SHALL enter SETUP with byte 0.
REQ-023 A 16-bit timeout counter SHALL clear on entering WAIT_HI and count through WAIT_HI and WAIT_LO; reaching TIMEOUT SHALL enter ERROR.
REQ-024 ERROR SHALL set error=1 and force i2c_copy_enable=0, and SHALL stay in ERROR until reset.
REQ-025 done and error SHALL never both be 1.
REQ-026 In IDLE, DONE and ERROR, i2c_din SHALL be 8'h00 and i2c_copy_enable SHALL be 0.
REQ-027 All outputs SHALL be registered; i2c_copy_enable SHALL be glitch-free.

Reset
REQ-028 Reset SHALL force the state to IDLE and set i2c_din=8'h00, i2c_copy_enable=0, index=0, done=0, error=0, and clear the byte select, pulse counter and timeout counter.
REQ-029 Reset asserted mid-PULSE SHALL drop i2c_copy_enable the next cycle without a further pulse.

Structure
REQ-030 A shared package SHALL hold the state encoding, the byte-select encoding and the default DEV_ADDR, N_ENTRIES, CE_HIGH and TIMEOUT values.
REQ-031 The register table SHALL be a sub-module audio_cfg_rom: combinational, 4-bit index in, 16-bit {reg,data} out, with unused entries returning 16'h0000.

Verification
REQ-032 Reset, then start=1 for one cycle with an I2C model that raises busy 10 cycles after the third falling strobe and holds it 200 cycles -> 33 strobes, each 4 cycles high; bytes 8'h34,reg,data per entry; done=1 after entry 10; index=10.
REQ-033 Model never asserts busy, TIMEOUT=100 -> error=1 exactly 100 cycles after entering WAIT_HI, done=0, no further strobes.
REQ-034 Reset asserted in the 2nd PULSE cycle of byte 1 -> i2c_copy_enable=0 the next cycle, all outputs at reset values, and a new start begins at index 0 byte 0.
REQ-035 start held high throughout the run -> the run executes once; a new run begins only from DONE, and an extra start in WAIT_LO has no effect.
REQ-036 N_ENTRIES=1, CE_HIGH=1 -> exactly 3 one-cycle strobes; i2c_din stable from SETUP through HOLD; done=1.
